// File: rtl/multicycle_control.sv
// Moore control FSM for the 32-bit multicycle MIPS datapath: HALT on illegal encodings, retired-instruction counter.
// Optional feature: define OVERFLOW_TRAP_EN to send overflowing add/sub/addi to HALT instead of write-back.

module multicycle_control #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               overflow,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               PCWriteCond,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               IRWrite,
  output logic [2:0]         ALUControl,
  output logic               halted,
  output logic [COUNT_W-1:0] instret
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    HALT    = 4'd12
  } state_t;

  typedef struct packed {
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic       alusrca;
    logic       regwrite;
    logic       regdst;
    logic       pcwritecond;
    logic       pcwrite;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic [2:0] alucontrol;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t FETCH_CTRL = '{
    pcsource: 2'b00, alusrcb: 2'b01, alusrca: 1'b0, regwrite: 1'b0,
    regdst: 1'b0, pcwritecond: 1'b0, pcwrite: 1'b1, iord: 1'b0,
    memread: 1'b1, memwrite: 1'b0, memtoreg: 1'b0, irwrite: 1'b1,
    alucontrol: ALU_ADD, halted: 1'b0
  };

  state_t       state;
  state_t       nxt;
  ctrl_t        ctrl;
  logic         funct_legal;
  logic [2:0]   funct_alu;
  logic         arith_trap;
  logic         addi_trap;
  logic         retire;

  // R-type funct decode shared by the next-state logic and the EXECUTE outputs
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  assign arith_trap = overflow && ((funct == FN_ADD) || (funct == FN_SUB));
  assign addi_trap  = overflow;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign arith_trap      = 1'b0;
  assign addi_trap       = 1'b0;
`endif

  always_comb begin
    nxt = HALT;
    case (state)
      FETCH: nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt = EXECUTE;
          OP_LW, OP_SW: nxt = MEMADR;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default:      nxt = HALT;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW)      nxt = MEMRD;
        else if (opcode == OP_SW) nxt = MEMWR;
        else                      nxt = HALT;
      end
      MEMRD:   nxt = MEMWB;
      MEMWB:   nxt = FETCH;
      MEMWR:   nxt = FETCH;
      EXECUTE: nxt = (funct_legal && !arith_trap) ? ALUWB : HALT;
      ALUWB:   nxt = FETCH;
      BRANCH:  nxt = FETCH;
      ADDIEX:  nxt = addi_trap ? HALT : ADDIWB;
      ADDIWB:  nxt = FETCH;
      JUMP:    nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = HALT;
    endcase
  end

  // Only terminal states ever move to FETCH, so this is exactly "an instruction retired"
  assign retire = (nxt == FETCH) && (state != FETCH);

  function automatic ctrl_t decode_ctrl(input state_t s, input logic [2:0] alu_r);
    ctrl_t c;
    c            = '0;
    c.alucontrol = ALU_ADD;
    case (s)
      FETCH:   c = FETCH_CTRL;
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   begin c.iord = 1'b1; c.memread = 1'b1; end
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      EXECUTE: begin c.alusrca = 1'b1; c.alusrcb = 2'b00; c.alucontrol = alu_r; end
      ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BRANCH: begin
        c.alusrca     = 1'b1;
        c.alucontrol  = ALU_SUB;
        c.pcsource    = 2'b01;
        c.pcwritecond = 1'b1;
      end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP:    begin c.pcsource = 2'b10; c.pcwrite = 1'b1; end
      HALT:    c.halted = 1'b1;
      default: c.halted = 1'b1;
    endcase
    return c;
  endfunction

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      ctrl    <= FETCH_CTRL;
      instret <= '0;
    end else begin
      state <= nxt;
      ctrl  <= decode_ctrl(nxt, funct_alu);
      if (retire) instret <= instret + COUNT_W'(1);
    end
  end

  assign PCSource    = ctrl.pcsource;
  assign ALUSrcB     = ctrl.alusrcb;
  assign ALUSrcA     = ctrl.alusrca;
  assign RegWrite    = ctrl.regwrite;
  assign RegDst      = ctrl.regdst;
  assign PCWriteCond = ctrl.pcwritecond;
  assign PCWrite     = ctrl.pcwrite;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.memread;
  assign MemWrite    = ctrl.memwrite;
  assign MemToReg    = ctrl.memtoreg;
  assign IRWrite     = ctrl.irwrite;
  assign ALUControl  = ctrl.alucontrol;
  assign halted      = ctrl.halted;

  a_reg_mem_exclusive: assert property (@(posedge clk) disable iff (!rst) !(RegWrite && MemWrite));
  a_pc_write_exclusive: assert property (@(posedge clk) disable iff (!rst) !(PCWrite && PCWriteCond));

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control using a per-instruction-class cycle model.
// Builds with or without OVERFLOW_TRAP_EN; the model follows the same macro.

module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        overflow;
  logic [1:0]  PCSource;
  logic [1:0]  ALUSrcB;
  logic        ALUSrcA;
  logic        RegWrite;
  logic        RegDst;
  logic        PCWriteCond;
  logic        PCWrite;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToReg;
  logic        IRWrite;
  logic [2:0]  ALUControl;
  logic        halted;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelCount = '0;

  typedef enum int {C_LW, C_SW, C_R, C_ADDI, C_BEQ, C_J, C_BADOP} iclass_t;

  multicycle_control #(.COUNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .overflow(overflow),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .IRWrite(IRWrite),
    .ALUControl(ALUControl), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  // Observed control word: {PCSource, ALUSrcB, strobes[9:0], ALUControl, halted}
  logic [17:0] obs;
  assign obs = {PCSource, ALUSrcB, ALUSrcA, RegWrite, RegDst, PCWriteCond, PCWrite,
                IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUControl, halted};

  localparam logic [9:0] S_SRCA = 10'b1000000000;
  localparam logic [9:0] S_RW   = 10'b0100000000;
  localparam logic [9:0] S_RDST = 10'b0010000000;
  localparam logic [9:0] S_PCWC = 10'b0001000000;
  localparam logic [9:0] S_PCW  = 10'b0000100000;
  localparam logic [9:0] S_IORD = 10'b0000010000;
  localparam logic [9:0] S_MRD  = 10'b0000001000;
  localparam logic [9:0] S_MWR  = 10'b0000000100;
  localparam logic [9:0] S_M2R  = 10'b0000000010;
  localparam logic [9:0] S_IRW  = 10'b0000000001;

  function automatic logic [17:0] sig(input logic [1:0] pcs, input logic [1:0] srcb,
                                      input logic [2:0] alu, input logic [9:0] strobes);
    return {pcs, srcb, strobes, alu, 1'b0};
  endfunction

  localparam logic [17:0] FETCH_SIG = {2'd0, 2'd1, (S_IRW | S_MRD | S_PCW), 3'b010, 1'b0};
  localparam logic [17:0] HALT_SIG  = {2'd0, 2'd0, 10'd0, 3'b010, 1'b1};

  // {legal, ALU code} for an R-type funct
  function automatic logic [3:0] ref_alu(input logic [5:0] f);
    case (f)
      6'h20:   return {1'b1, 3'b010};
      6'h22:   return {1'b1, 3'b110};
      6'h24:   return {1'b1, 3'b000};
      6'h25:   return {1'b1, 3'b001};
      6'h2a:   return {1'b1, 3'b111};
      default: return {1'b0, 3'b010};
    endcase
  endfunction

  // Expected control word for cycle `cyc` (1 = fetch) of an instruction of class `cls`
  function automatic logic [17:0] expect_cycle(input iclass_t cls, input int cyc, input logic [5:0] f);
    logic [3:0] a;
    a = ref_alu(f);
    if (cyc == 1) return FETCH_SIG;
    if (cyc == 2) return sig(2'd0, 2'd3, 3'b010, 10'd0);
    case (cls)
      C_LW: begin
        if (cyc == 3) return sig(2'd0, 2'd2, 3'b010, S_SRCA);
        if (cyc == 4) return sig(2'd0, 2'd0, 3'b010, S_IORD | S_MRD);
        return sig(2'd0, 2'd0, 3'b010, S_M2R | S_RW);
      end
      C_SW: begin
        if (cyc == 3) return sig(2'd0, 2'd2, 3'b010, S_SRCA);
        return sig(2'd0, 2'd0, 3'b010, S_IORD | S_MWR);
      end
      C_R: begin
        if (cyc == 3) return sig(2'd0, 2'd0, a[2:0], S_SRCA);
        return sig(2'd0, 2'd0, 3'b010, S_RDST | S_RW);
      end
      C_ADDI: begin
        if (cyc == 3) return sig(2'd0, 2'd2, 3'b010, S_SRCA);
        return sig(2'd0, 2'd0, 3'b010, S_RW);
      end
      C_BEQ:   return sig(2'd1, 2'd0, 3'b110, S_SRCA | S_PCWC);
      C_J:     return sig(2'd2, 2'd0, 3'b010, S_PCW);
      default: return HALT_SIG;
    endcase
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
  endfunction

  // Assert reset for a few cycles and release it; ends 1 time unit after a falling clock edge in FETCH
  task automatic applyStimulus_reset(input int hold);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== FETCH_SIG) begin errors++; $display("[TB] FAIL reset_outputs: got %h expected %h", obs, FETCH_SIG); end
    checks++;
    if (instret !== 32'd0) begin errors++; $display("[TB] FAIL reset_instret: got %0d expected 0", instret); end
    repeat (hold) @(negedge clk);
    #1;
    checks++;
    if (obs !== FETCH_SIG) begin errors++; $display("[TB] FAIL reset_hold_outputs: got %h expected %h", obs, FETCH_SIG); end
    rst = 1'b1;
    modelCount = '0;
  endtask

  task automatic run_instr(input iclass_t cls, input logic [5:0] f, input logic ovf, input logic [5:0] badop);
    int lat;
    int haltAfter;
    int n;
    logic trap;
    logic [3:0] a;
    logic [17:0] expV;
    a = ref_alu(f);
    case (cls)
      C_LW:    begin opcode = 6'b100011; lat = 5; end
      C_SW:    begin opcode = 6'b101011; lat = 4; end
      C_R:     begin opcode = 6'b000000; lat = 4; end
      C_ADDI:  begin opcode = 6'b001000; lat = 4; end
      C_BEQ:   begin opcode = 6'b000100; lat = 3; end
      C_J:     begin opcode = 6'b000010; lat = 3; end
      default: begin opcode = badop;     lat = 2; end
    endcase
    funct    = f;
    overflow = ovf;
    trap     = 1'b0;
`ifdef OVERFLOW_TRAP_EN
    trap = ovf && ((cls == C_R && (f == 6'h20 || f == 6'h22)) || cls == C_ADDI);
`endif
    haltAfter = 0;
    if (cls == C_BADOP) haltAfter = 2;
    else if ((cls == C_R && !a[3]) || trap) haltAfter = 3;
    n = (haltAfter != 0) ? haltAfter : lat;
    for (int cyc = 1; cyc <= n; cyc++) begin
      expV = expect_cycle(cls, cyc, f);
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("[TB] FAIL ctrl class%0d op%b fn%b cyc%0d: got %h expected %h", cls, opcode, f, cyc, obs, expV);
      end
      @(negedge clk);
      #1;
    end
    if (haltAfter != 0) begin
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (obs !== HALT_SIG) begin errors++; $display("[TB] FAIL halt_outputs cyc%0d: got %h expected %h", k, obs, HALT_SIG); end
        checks++;
        if (instret !== modelCount) begin errors++; $display("[TB] FAIL halt_instret: got %0d expected %0d", instret, modelCount); end
        @(negedge clk);
        #1;
      end
      applyStimulus_reset(2);
    end else begin
      modelCount = modelCount + 32'd1;
      checks++;
      if (instret !== modelCount) begin errors++; $display("[TB] FAIL instret class%0d: got %0d expected %0d", cls, instret, modelCount); end
    end
  endtask

  task automatic test_reset;
    applyStimulus_reset(3);
    #1;
    checks++;
    if (obs !== FETCH_SIG || halted !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_fetch: got %h expected %h", obs, FETCH_SIG); end
  endtask

  task automatic test_lw;
    run_instr(C_LW, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 6'd0);
  endtask

  task automatic test_rtype_sw;
    run_instr(C_R, 6'b100010, 1'b0, 6'd0);
    run_instr(C_SW, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 6'd0);
  endtask

  task automatic test_branch_jump;
    logic [31:0] base;
    base = modelCount;
    run_instr(C_BEQ, 6'($urandom_range(0, 63)), 1'b0, 6'd0);
    run_instr(C_J, 6'($urandom_range(0, 63)), 1'b1, 6'd0);
    checks++;
    if (instret !== base + 32'd2) begin errors++; $display("[TB] FAIL beq_j_count: got %0d expected %0d", instret, base + 32'd2); end
  endtask

  task automatic test_illegal;
    run_instr(C_ADDI, 6'd0, 1'b0, 6'd0);
    run_instr(C_BADOP, 6'd0, 1'b0, 6'b111111);
    run_instr(C_LW, 6'd0, 1'b0, 6'd0);
    run_instr(C_R, 6'b000001, 1'b0, 6'd0);
  endtask

  task automatic test_mid_reset;
    logic [17:0] expV;
    run_instr(C_R, 6'h25, 1'b0, 6'd0);
    run_instr(C_ADDI, 6'd0, 1'b0, 6'd0);
    opcode   = 6'b100011;
    overflow = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      expV = expect_cycle(C_LW, cyc, funct);
      checks++;
      if (obs !== expV) begin errors++; $display("[TB] FAIL midreset_lw cyc%0d: got %h expected %h", cyc, obs, expV); end
      if (cyc < 4) begin @(negedge clk); #1; end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== FETCH_SIG) begin errors++; $display("[TB] FAIL midreset_outputs: got %h expected %h", obs, FETCH_SIG); end
    checks++;
    if (instret !== 32'd0) begin errors++; $display("[TB] FAIL midreset_instret: got %0d expected 0", instret); end
    @(negedge clk);
    #1;
    checks++;
    if (RegWrite !== 1'b0 || obs !== FETCH_SIG) begin errors++; $display("[TB] FAIL midreset_hold: got %h expected %h", obs, FETCH_SIG); end
    rst = 1'b1;
    modelCount = '0;
    run_instr(C_J, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic test_overflow;
    run_instr(C_R, 6'h20, 1'b1, 6'd0);
    run_instr(C_R, 6'h22, 1'b1, 6'd0);
    run_instr(C_R, 6'h24, 1'b1, 6'd0);
    run_instr(C_ADDI, 6'd0, 1'b1, 6'd0);
  endtask

  task automatic test_random;
    logic [5:0] legalFn [5];
    iclass_t cls;
    logic [5:0] f;
    logic [5:0] bad;
    legalFn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    for (int i = 0; i < 60; i++) begin
      cls = iclass_t'($urandom_range(0, 6));
      if (cls == C_BADOP && $urandom_range(0, 2) != 0) cls = C_R;
      f = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : legalFn[$urandom_range(0, 4)];
      bad = 6'($urandom_range(0, 63));
      while (is_legal_op(bad)) bad = 6'($urandom_range(0, 63));
      run_instr(cls, f, 1'($urandom_range(0, 1)), bad);
    end
  endtask

  initial begin
    rst      = 1'b0;
    opcode   = 6'd0;
    funct    = 6'd0;
    overflow = 1'b0;
    test_reset;
    test_lw;
    test_rtype_sw;
    test_branch_jump;
    test_illegal;
    test_mid_reset;
    test_overflow;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the team's 32-bit multicycle MIPS datapath.
- Decodes the opcode and funct fields of the held instruction register.
- Drives every datapath select/enable and the ALU operation code.
- Adds a halt state for illegal encodings and a retired-instruction counter for bring-up and benches.

Parameters:
- COUNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted
- opcode  in  6  Instr[31:26] from the datapath instruction register
- funct  in  6  Instr[5:0]
- overflow  in  1  ALU overflow flag (used only with the optional feature)
- PCSource  out  2  0 ALUResult, 1 ALUOut, 2 jump target
- ALUSrcB  out  2  0 B, 1 const 4, 2 SignImm, 3 SignImm<<2
- ALUSrcA  out  1  0 PC, 1 A
- RegWrite  out  1  register-file write enable
- RegDst  out  1  0 rt, 1 rd
- PCWriteCond  out  1  branch PC write (qualified by Zero)
- PCWrite  out  1  unconditional PC write
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- MemToReg  out  1  write-back data: 0 ALUOut, 1 Data
- IRWrite  out  1  instruction-register load
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- halted  out  1  high while in HALT
- instret  out  COUNT_W  retired-instruction count

Behaviour:
- State register uses 4-bit encoding. Asynchronous reset clears it to FETCH and clears instret to 0.
- Outputs are decoded from state only, except ALUControl in EXECUTE, which also uses funct.
- Any signal not listed for a state is 0. ALUControl defaults to 010.
- During reset, outputs take FETCH values; the datapath is held in reset by the same rst.
- FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1, PCSource=00 -> DECODE.
- DECODE: ALUSrcB=11, computing the branch target into ALUOut. Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other opcode -> HALT
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next state: lw -> MEMRD; sw -> MEMWR.
- MEMRD: IorD=1, MemRead=1 -> MEMWB.
- MEMWB: MemToReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1 -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUControl by funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - next state: ALUWB for legal funct; HALT for any other funct (ALUControl=010).
- ALUWB: RegDst=1, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUControl=110, PCSource=01, PCWriteCond=1 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10 -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0 -> FETCH.
- JUMP: PCSource=10, PCWrite=1 -> FETCH.
- HALT: all strobes 0, halted=1. Sticky until rst is asserted.
- Latencies in clocks, FETCH to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- instret increments by 1 on every clock edge whose next state is FETCH from a terminal state (MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP).
  - It wraps modulo 2^COUNT_W.
  - It never increments while in or entering HALT.
- Reset asserted mid-instruction: the state returns immediately to FETCH and instret goes to 0. No partial write strobe may remain asserted after rst falls.
- Register writes never coincide with memory writes. PCWrite and PCWriteCond are never both 1.

Optional Feature:
- Macro OVERFLOW_TRAP_EN.
- Defined: in EXECUTE with funct add/sub and in ADDIEX, overflow=1 sends the next state to HALT instead of the write-back state. There is no register write and no instret increment.
- Undefined: the overflow input is ignored, and arithmetic wraps as two's complement with normal write-back.

Test Plan:
- Reset: hold rst=0 then release -> state FETCH, instret=0, halted=0; first edge asserts IRWrite=1 and PCWrite=1.
- lw (opcode 100011) -> FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegWrite=1 and MemToReg=1 only in cycle 5; instret goes 0->1.
- R-type sub (opcode 0, funct 100010) -> ALUControl=110 in EXECUTE; RegDst=1, RegWrite=1 in cycle 4. sw -> MemWrite=1 only in cycle 4, IorD=1.
- beq then j -> each takes 3 cycles. BRANCH drives PCWriteCond=1, PCSource=01, ALUControl=110. JUMP drives PCWrite=1, PCSource=10. instret=2 after both.
- Illegal opcode 111111, or funct 000001 -> HALT with halted=1, all strobes 0 for 20 cycles, instret frozen; only rst=0 exits to FETCH.
- rst=0 asserted in MEMRD -> state FETCH and instret=0 immediately, with no MemWB RegWrite. With OVERFLOW_TRAP_EN, add with overflow=1 in EXECUTE -> HALT, RegWrite never 1.
